// File: rtl/vga_pkg.sv
// Shared framebuffer definitions for the VGA subsystem.
// Holds the screen geometry, the pixel-write word carried between the
// requesters and the framebuffer, the arbiter grant encoding and a helper
// that tells whether a pixel lies on the visible screen.
package vga_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 200;
   localparam int FB_X_W    = 9;
   localparam int FB_Y_W    = 8;
   localparam int COLOR_W   = 8;

   typedef struct packed {
      logic [FB_X_W-1:0]  x;
      logic [FB_Y_W-1:0]  y;
      logic [COLOR_W-1:0] data;
   } fb_pixel_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

   function automatic logic pixel_in_range(input fb_pixel_t p);
      return (p.x < FB_X_W'(FB_WIDTH)) && (p.y < FB_Y_W'(FB_HEIGHT));
   endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous FIFO of framebuffer pixel words.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (pointers only)
//   push, din   - write request and word; ignored when full unless a pop
//                 happens at the same edge
//   pop, dout   - read request and head word (no read latency)
//   empty, full - occupancy flags from the wrap-bit pointer pair
module fb_pixel_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  fb_pixel_t din,
   output fb_pixel_t dout,
   output logic      empty,
   output logic      full
);

   localparam int AW = $clog2(DEPTH);

   fb_pixel_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_pop;
   logic           do_push;

   // A pop at the same edge frees the head slot, so a push into a full
   // FIFO is still accepted then; the write lands in the slot being read.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter.
// Port A (UART command parser) issues one-cycle write strobes that are
// buffered in a FIFO; port B (fill/blit engine) uses valid/ready. A
// round-robin scheduler loads one registered output slot that drives the
// framebuffer with a valid/ready handshake. Off-screen pixels are consumed
// at grant but never reach the slot.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   a_write_enable/x/y/data          - port A strobe and pixel
//   a_overflow, overflow_count       - dropped-write pulse and saturating count
//   b_valid, b_ready, b_x/y/data     - port B request handshake and pixel
//   fb_write_enable/x/y/data, fb_ready - framebuffer write handshake
//   busy                             - FIFO non-empty or slot occupied
module fb_write_arbiter
   import vga_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a_write_enable,
   input  logic [FB_X_W-1:0]  a_write_x,
   input  logic [FB_Y_W-1:0]  a_write_y,
   input  logic [COLOR_W-1:0] a_write_data,
   output logic               a_overflow,
   output logic [7:0]         overflow_count,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [FB_X_W-1:0]  b_x,
   input  logic [FB_Y_W-1:0]  b_y,
   input  logic [COLOR_W-1:0] b_data,
   output logic               fb_write_enable,
   output logic [FB_X_W-1:0]  fb_write_x,
   output logic [FB_Y_W-1:0]  fb_write_y,
   output logic [COLOR_W-1:0] fb_write_data,
   input  logic               fb_ready,
   output logic               busy
);

   fb_pixel_t a_pix;
   fb_pixel_t b_pix;
   fb_pixel_t head;
   fb_pixel_t grant_pix;
   fb_pixel_t slot_p0;
   logic      vld_p0;
   logic      fifo_empty;
   logic      fifo_full;
   logic      load_ok;
   logic      grant_a;
   logic      grant_b;
   logic      drop;
   grant_t    last_grant;

   assign a_pix = '{x: a_write_x, y: a_write_y, data: a_write_data};
   assign b_pix = '{x: b_x, y: b_y, data: b_data};

   fb_pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (a_write_enable),
      .pop   (grant_a),
      .din   (a_pix),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // The slot may take a new pixel when it is empty or its current write
   // completes at this edge.
   assign load_ok = !vld_p0 || fb_ready;

   // B is offered the port unless the FIFO is waiting and A is owed a turn.
   assign b_ready = load_ok && (fifo_empty || (last_grant == GRANT_A));
   assign grant_b = b_valid && b_ready;
   assign grant_a = load_ok && !fifo_empty &&
                    (!b_valid || (last_grant == GRANT_B));

   assign grant_pix = grant_a ? head : b_pix;

   // The FIFO's own guard agrees: full with no pop means the push is lost.
   assign drop = a_write_enable && fifo_full && !grant_a;

   // ---- output slot (stage p0) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0     <= 1'b0;
         slot_p0    <= '0;
         last_grant <= GRANT_B;
      end else begin
         if ((grant_a || grant_b) && pixel_in_range(grant_pix)) begin
            vld_p0  <= 1'b1;
            slot_p0 <= grant_pix;
         end else if (fb_ready) begin
            vld_p0  <= 1'b0;
         end
         if (grant_a)      last_grant <= GRANT_A;
         else if (grant_b) last_grant <= GRANT_B;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_overflow     <= 1'b0;
         overflow_count <= '0;
      end else begin
         a_overflow <= drop;
         if (drop && (overflow_count != 8'hFF))
            overflow_count <= overflow_count + 8'd1;
      end
   end

   assign fb_write_enable = vld_p0;
   assign fb_write_x      = slot_p0.x;
   assign fb_write_y      = slot_p0.y;
   assign fb_write_data   = slot_p0.data;
   assign busy            = !fifo_empty || vld_p0;

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;
   import vga_pkg::*;

   localparam int FIFO_DEPTH = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               a_write_enable;
   logic [FB_X_W-1:0]  a_write_x;
   logic [FB_Y_W-1:0]  a_write_y;
   logic [COLOR_W-1:0] a_write_data;
   logic               a_overflow;
   logic [7:0]         overflow_count;
   logic               b_valid;
   logic               b_ready;
   logic [FB_X_W-1:0]  b_x;
   logic [FB_Y_W-1:0]  b_y;
   logic [COLOR_W-1:0] b_data;
   logic               fb_write_enable;
   logic [FB_X_W-1:0]  fb_write_x;
   logic [FB_Y_W-1:0]  fb_write_y;
   logic [COLOR_W-1:0] fb_write_data;
   logic               fb_ready;
   logic               busy;

   always #5 clk = ~clk;

   fb_write_arbiter #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .a_write_enable  (a_write_enable),
      .a_write_x       (a_write_x),
      .a_write_y       (a_write_y),
      .a_write_data    (a_write_data),
      .a_overflow      (a_overflow),
      .overflow_count  (overflow_count),
      .b_valid         (b_valid),
      .b_ready         (b_ready),
      .b_x             (b_x),
      .b_y             (b_y),
      .b_data          (b_data),
      .fb_write_enable (fb_write_enable),
      .fb_write_x      (fb_write_x),
      .fb_write_y      (fb_write_y),
      .fb_write_data   (fb_write_data),
      .fb_ready        (fb_ready),
      .busy            (busy)
   );

   fb_pixel_t sb_q[$];
   int        checks = 0;
   int        errors = 0;
   logic      stall_prev = 1'b0;
   fb_pixel_t stall_pix;

   function automatic fb_pixel_t px(input int x, input int y, input int d);
      fb_pixel_t p;
      p.x    = FB_X_W'(x);
      p.y    = FB_Y_W'(y);
      p.data = COLOR_W'(d);
      return p;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic a_drive(input logic en, input fb_pixel_t p);
      a_write_enable = en;
      a_write_x      = p.x;
      a_write_y      = p.y;
      a_write_data   = p.data;
   endtask

   task automatic b_drive(input logic v, input fb_pixel_t p);
      b_valid = v;
      b_x     = p.x;
      b_y     = p.y;
      b_data  = p.data;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_drive(1'b0, px(0, 0, 0));
      b_drive(1'b0, px(0, 0, 0));
      fb_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      fb_ready = 1'b1;
      a_drive(1'b0, px(0, 0, 0));
      b_drive(1'b0, px(0, 0, 0));
      while (sb_q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      chk({name, "_drained"}, sb_q.size(), 0);
      sb_q.delete();
      step();
      smp();
      chk({name, "_busy_low"}, busy, 0);
      step();
   endtask

   // Monitor: compares every completed framebuffer write against the
   // scoreboard and checks the slot stays stable while stalled.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && fb_write_enable)
            chk("slot_stable", int'({fb_write_x, fb_write_y, fb_write_data}),
                int'(stall_pix));
         if (fb_write_enable && fb_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got x=%0d y=%0d d=%0h, required none",
                        fb_write_x, fb_write_y, fb_write_data);
            end else begin
               fb_pixel_t e;
               e = sb_q.pop_front();
               checks++;
               if (fb_write_x != e.x || fb_write_y != e.y || fb_write_data != e.data) begin
                  errors++;
                  $display("FAIL fb_write: got x=%0d y=%0d d=%0h, required x=%0d y=%0d d=%0h",
                           fb_write_x, fb_write_y, fb_write_data, e.x, e.y, e.data);
               end
            end
         end
         stall_prev = fb_write_enable && !fb_ready;
         stall_pix  = px(int'(fb_write_x), int'(fb_write_y), int'(fb_write_data));
      end
   end

   initial begin
      fb_pixel_t av[8];
      fb_pixel_t bv[3];
      int bi;

      // ---- reset values and single A write ----
      do_reset();
      smp();
      chk("rst_fb_we", fb_write_enable, 0);
      chk("rst_fb_xyd", int'({fb_write_x, fb_write_y, fb_write_data}), 0);
      chk("rst_overflow", a_overflow, 0);
      chk("rst_ovf_count", overflow_count, 0);
      chk("rst_busy", busy, 0);
      step();
      fb_ready = 1'b1;
      a_drive(1'b1, px(10, 20, 8'h3C));
      sb_q.push_back(px(10, 20, 8'h3C));
      step();
      a_drive(1'b0, px(0, 0, 0));
      smp();
      chk("a_lat_t_we", fb_write_enable, 0);
      chk("a_lat_t_busy", busy, 1);
      step();
      smp();
      chk("a_lat_t1_we", fb_write_enable, 1);
      step();
      smp();
      chk("a_lat_t2_we", fb_write_enable, 0);
      chk("a_lat_t2_busy", busy, 0);
      step();

      // ---- both sources saturated: A,B alternate at one write per cycle ----
      do_reset();
      fb_ready = 1'b1;
      for (int i = 0; i < 4; i++) av[i] = px(100 + i, 10 + i, 8'hA0 + i);
      for (int i = 0; i < 3; i++) bv[i] = px(200 + i, 50 + i, 8'hB0 + i);
      sb_q.push_back(av[0]); sb_q.push_back(bv[0]);
      sb_q.push_back(av[1]); sb_q.push_back(bv[1]);
      sb_q.push_back(av[2]); sb_q.push_back(bv[2]);
      sb_q.push_back(av[3]);
      bi = 0;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) a_drive(1'b1, av[c]);
         else       a_drive(1'b0, px(0, 0, 0));
         if (c >= 1 && bi < 3) b_drive(1'b1, bv[bi]);
         else                  b_drive(1'b0, px(0, 0, 0));
         smp();
         if (c >= 1 && c <= 6) chk("sat_b_ready", b_ready, (c % 2 == 0) ? 1 : 0);
         if (c >= 2) chk("sat_fb_we", fb_write_enable, 1);
         if (b_valid && b_ready) bi++;
         step();
      end
      chk("sat_b_accepted", bi, 3);
      drain("sat");

      // ---- stall: 6 strobes, one dropped ----
      do_reset();
      fb_ready = 1'b0;
      for (int i = 0; i < 6; i++) av[i] = px(i + 1, i + 2, 8'h10 + i);
      for (int i = 0; i < 5; i++) sb_q.push_back(av[i]);
      for (int c = 0; c < 10; c++) begin
         if (c < 6) a_drive(1'b1, av[c]);
         else       a_drive(1'b0, px(0, 0, 0));
         smp();
         if (c >= 2) chk("stall_fb_we", fb_write_enable, 1);
         if (c == 5) chk("stall_ovf_c5", a_overflow, 0);
         if (c == 6) begin
            chk("stall_ovf_c6", a_overflow, 1);
            chk("stall_cnt_c6", overflow_count, 1);
         end
         if (c == 7) begin
            chk("stall_ovf_c7", a_overflow, 0);
            chk("stall_cnt_c7", overflow_count, 1);
         end
         step();
      end
      drain("stall");

      // ---- pop and push at the same edge with the FIFO full ----
      for (int i = 0; i < 8; i++) av[i] = px(40 + i, 70 + i, 8'hC0 + i);
      for (int i = 0; i < 8; i++) sb_q.push_back(av[i]);
      for (int c = 0; c < 10; c++) begin
         fb_ready = (c >= 5 && c <= 7) || (c == 9);
         if (c < 8)       a_drive(1'b1, av[c]);
         else if (c == 8) a_drive(1'b1, px(1, 1, 1));
         else             a_drive(1'b0, px(0, 0, 0));
         smp();
         if (c >= 6 && c <= 8) begin
            chk("pp_no_overflow", a_overflow, 0);
            chk("pp_count_held", overflow_count, 1);
         end
         if (c == 9) begin
            chk("pp_still_full_ovf", a_overflow, 1);
            chk("pp_still_full_cnt", overflow_count, 2);
         end
         step();
      end
      drain("pushpop");

      // ---- out-of-range entries are consumed, never written ----
      do_reset();
      fb_ready = 1'b1;
      sb_q.push_back(px(30, 40, 8'h77));
      sb_q.push_back(px(50, 60, 8'h88));
      a_drive(1'b1, px(0, 200, 8'h55));
      smp();
      chk("oor_we_c0", fb_write_enable, 0);
      step();
      a_drive(1'b0, px(0, 0, 0));
      b_drive(1'b1, px(320, 5, 8'h66));
      smp();
      chk("oor_b_ready_c1", b_ready, 0);
      chk("oor_we_c1", fb_write_enable, 0);
      step();
      smp();
      chk("oor_b_ready_c2", b_ready, 1);
      chk("oor_we_c2", fb_write_enable, 0);
      chk("oor_busy_c2", busy, 0);
      step();
      b_drive(1'b0, px(0, 0, 0));
      a_drive(1'b1, px(30, 40, 8'h77));
      smp();
      chk("oor_we_c3", fb_write_enable, 0);
      chk("oor_busy_c3", busy, 0);
      step();
      a_drive(1'b0, px(0, 0, 0));
      b_drive(1'b1, px(50, 60, 8'h88));
      smp();
      chk("oor_last_grant_b", b_ready, 0);
      step();
      smp();
      chk("oor_b_ready_c5", b_ready, 1);
      step();
      drain("oor");

      // ---- reset while stalled discards everything ----
      fb_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         a_drive(1'b1, px(5 + c, 6 + c, 8'hE0 + c));
         if (c >= 1) b_drive(1'b1, px(9, 9, 8'hEE));
         step();
      end
      a_drive(1'b0, px(0, 0, 0));
      smp();
      chk("mid_pre_we", fb_write_enable, 1);
      chk("mid_pre_busy", busy, 1);
      step();
      reset = 1'b1;
      b_drive(1'b0, px(0, 0, 0));
      step();
      reset = 1'b0;
      smp();
      chk("mid_post_we", fb_write_enable, 0);
      chk("mid_post_busy", busy, 0);
      fb_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         smp();
         chk("mid_no_stale", fb_write_enable, 0);
      end

      chk("final_sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required finish before 200000");
      $fatal(1);
   end

endmodule
